// File: rtl/scim_pkg.sv
// Shared definitions for the stochastic CIM macro with stream accumulation:
// parameter defaults, derived widths and the run-control state encoding.
package scim_pkg;

    localparam int N_R_DEF   = 81;
    localparam int N_S_DEF   = 32;
    localparam int N_C_DEF   = 32;
    localparam int FXP_DEF   = 6;
    localparam int WSEG_DEF  = 3;
    localparam int CNT_W_DEF = 8;

    localparam int NSEG_DEF  = FXP_DEF / WSEG_DEF;
    localparam int ACC_W_DEF = CNT_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    function automatic int nseg(input int fxp, input int wseg);
        return fxp / wseg;
    endfunction

    function automatic int acc_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/scim_sng_row.sv
// One macro row: segmented sign-magnitude weight store and the
// stochastic number generator producing per-slice positive/negative hits.
module scim_sng_row
    import scim_pkg::*;
#(
    parameter int N_S  = N_S_DEF,
    parameter int FXP  = FXP_DEF,
    parameter int WSEG = WSEG_DEF,
    parameter int NSEG = NSEG_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  wr_en,
    input  logic [NSEG-1:0]       wl,
    input  logic [N_S*WSEG-1:0]   din,
    input  logic [FXP-1:0]        rn,
    output logic [N_S-1:0]        sp,
    output logic [N_S-1:0]        sn
);

    // Sign bit is masked out so the random number only meets magnitude bits.
    localparam logic [FXP-1:0] MAG = {1'b0, {(FXP-1){1'b1}}};

    logic [FXP-1:0] w [N_S];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int h = 0; h < N_S; h++)
                w[h] <= '0;
        end else if (wr_en) begin
            for (int h = 0; h < N_S; h++)
                for (int s = 0; s < NSEG; s++)
                    if (wl[s])
                        w[h][s*WSEG +: WSEG] <= din[h*WSEG +: WSEG];
        end
    end

    always_comb begin
        sp = '0;
        sn = '0;
        for (int h = 0; h < N_S; h++) begin
            sp[h] = (|(w[h] & rn & MAG)) & ~w[h][FXP-1];
            sn[h] = (|(w[h] & rn & MAG)) &  w[h][FXP-1];
        end
    end

endmodule

// File: rtl/scim_macro_acc.sv
// Stochastic CIM macro: row SNGs, line-wise OR compute, and a run
// controller that accumulates P-minus-N counts over a stream.
module scim_macro_acc
    import scim_pkg::*;
#(
    parameter int N_R   = N_R_DEF,
    parameter int N_S   = N_S_DEF,
    parameter int N_C   = N_C_DEF,
    parameter int FXP   = FXP_DEF,
    parameter int WSEG  = WSEG_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [N_R*N_C-1:0]             I,
    input  logic [N_R*FXP-1:0]             RN,
    input  logic [N_R*(FXP/WSEG)-1:0]      WL,
    input  logic [N_S*WSEG-1:0]            DIN,
    input  logic                           WRITE_EN,
    input  logic                           START,
    input  logic                           MODE,
    input  logic [CNT_W-1:0]               LEN,
    output logic [N_S*N_C-1:0]             DOUTP,
    output logic [N_S*N_C-1:0]             DOUTN,
    output logic [N_S*N_C*(CNT_W+1)-1:0]   ACC,
    output logic                           BUSY,
    output logic                           DONE
);

    localparam int NSEG  = nseg(FXP, WSEG);
    localparam int ACC_W = acc_w(CNT_W);
    localparam int NB    = N_S * N_C;

    logic [N_S-1:0]   sp_row [N_R];
    logic [N_S-1:0]   sn_row [N_R];
    logic [NB-1:0]    p_hit;
    logic [NB-1:0]    n_hit;
    logic [ACC_W-1:0] acc [NB];
    logic [CNT_W-1:0] cnt;
    logic             wr_ok;
    state_t           state;

    assign wr_ok = WRITE_EN & ~BUSY;

    for (genvar l = 0; l < N_R; l++) begin : g_row
        scim_sng_row #(
            .N_S  (N_S),
            .FXP  (FXP),
            .WSEG (WSEG),
            .NSEG (NSEG)
        ) u_row (
            .CLK   (CLK),
            .RESET (RESET),
            .wr_en (wr_ok),
            .wl    (WL[l*NSEG +: NSEG]),
            .din   (DIN),
            .rn    (RN[l*FXP +: FXP]),
            .sp    (sp_row[l]),
            .sn    (sn_row[l])
        );
    end

    always_comb begin
        p_hit = '0;
        n_hit = '0;
        for (int j = 0; j < N_S; j++)
            for (int p = 0; p < N_C; p++)
                for (int l = 0; l < N_R; l++) begin
                    p_hit[j*N_C+p] = p_hit[j*N_C+p] | (I[l*N_C+p] & sp_row[l][j]);
                    n_hit[j*N_C+p] = n_hit[j*N_C+p] | (I[l*N_C+p] & sn_row[l][j]);
                end
    end

    // DONE is registered out of FIN, so it pulses in the cycle after FIN.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            DOUTP <= '0;
            DOUTN <= '0;
            for (int k = 0; k < NB; k++)
                acc[k] <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        for (int k = 0; k < NB; k++)
                            acc[k] <= '0;
                        if (MODE && LEN == '0) begin
                            cnt   <= '0;
                            state <= FIN;
                        end else begin
                            cnt   <= MODE ? LEN : CNT_W'(1);
                            BUSY  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    DOUTP <= p_hit;
                    DOUTN <= n_hit;
                    for (int k = 0; k < NB; k++)
                        acc[k] <= acc[k] + ACC_W'(p_hit[k]) - ACC_W'(n_hit[k]);
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    DONE  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_acc
        assign ACC[k*ACC_W +: ACC_W] = acc[k];
    end

endmodule

// File: doc/scim_macro_acc.md
SCIM_MACRO_ACC -- requirements
Module: scim_macro_acc

Interface
REQ-001 Parameter N_R, default 81, number of rows.
REQ-002 Parameter N_S, default 32, number of weight slices.
REQ-003 Parameter N_C, default 32, number of compute (input) lines.
REQ-004 Parameter FXP, default 6, weight width, sign-magnitude, MSB = sign.
REQ-005 Parameter WSEG, default 3, bits per wordline segment; NSEG = FXP/WSEG wordlines per row; FXP SHALL be a multiple of WSEG.
REQ-006 Parameter CNT_W, default 8, stream-length counter width.
REQ-007 CLK  in  1  clock; all state changes on the rising edge.
REQ-008 RESET  in  1  reset, asynchronous, active-high.
REQ-009 I  in  N_R*N_C  input bits; I[l*N_C+p] is row l, line p.
REQ-010 RN  in  N_R*FXP  per-row random number; RN[l*FXP +: FXP] is row l.
REQ-011 WL  in  N_R*NSEG  wordline selects; several may be high at once.
REQ-012 DIN  in  N_S*WSEG  write data; DIN[h*WSEG +: WSEG] is slice h.
REQ-013 WRITE_EN  in  1  write strobe.
REQ-014 START  in  1  starts one compute run.
REQ-015 MODE  in  1  0 = single-shot, 1 = accumulate over LEN cycles.
REQ-016 LEN  in  CNT_W  stream length for MODE=1.
REQ-017 DOUTP / DOUTN  out  N_S*N_C each  registered positive/negative hits; bit j*N_C+p is slice j, line p.
REQ-018 ACC  out  N_S*N_C*(CNT_W+1)  signed two's-complement counts; field (j*N_C+p) holds count(P) minus count(N).
REQ-019 BUSY  out  1  high in RUN.
REQ-020 DONE  out  1  one-cycle pulse when ACC is final.

Function
REQ-021 Write: when WRITE_EN=1 and BUSY=0 at an edge, for every WL[l*NSEG+s]=1, weight bits [s*WSEG +: WSEG] of row l, slice h SHALL take DIN[h*WSEG +: WSEG]; a write while BUSY=1 SHALL be ignored.
REQ-022 SNG: hit(l,h) = OR over the magnitude bits [FXP-2:0] of (W(l,h) AND RN row l); the sign bit SHALL NOT take part in the AND.
REQ-023 sp(l,h) = hit AND NOT sign; sn(l,h) = hit AND sign.
REQ-024 Compute: P(j,p) = OR over l of (I[l*N_C+p] AND sp(l,j)); N(j,p) is defined the same way with sn.
REQ-025 FSM states IDLE, RUN, FIN.
REQ-026 IDLE to RUN on START=1: clear ACC and load counter with LEN, or with 1 if MODE=0; MODE is captured at START.
REQ-027 START with MODE=1 and LEN=0: go to FIN; ACC is cleared and DOUTP/DOUTN are unchanged.
REQ-028 Each RUN cycle: DOUTP/DOUTN take P/N from the current-cycle I/RN; ACC field += P minus N (in {-1, 0, +1}); counter decrements.
REQ-029 RUN to FIN on the edge where the counter goes from 1 to 0; FIN to IDLE unconditionally; DONE=1 only in FIN.
REQ-030 Latency: START sampled at edge t; samples at edges t+1 .. t+L; DONE high in the cycle after edge t+L+1.
REQ-031 START in RUN or FIN SHALL be ignored.
REQ-032 ACC and DOUTP/DOUTN hold their values outside RUN until the next START.
REQ-033 ACC never overflows, since |ACC| <= LEN <= 2^CNT_W - 1.

Reset
REQ-034 RESET=1 forces, asynchronously: state IDLE, counter 0, DOUTP=0, DOUTN=0, ACC=0, BUSY=0, DONE=0, and all weight storage 0.
REQ-035 RESET during RUN aborts the run with no DONE pulse; START is honoured from the first edge after RESET deasserts.

Structure
REQ-036 Shared package scim_pkg SHALL hold the FSM state enum (IDLE/RUN/FIN), the parameter defaults, and the NSEG and ACC_W = CNT_W+1 derivations.
REQ-037 Sub-module scim_sng_row (one row: stored weights plus RN to sp/sn for N_S slices) SHALL be instantiated N_R times; FSM, counter and accumulators stay in the top.

Verification (N_R=3, N_S=2, N_C=2, FXP=6, WSEG=3, CNT_W=4)
REQ-038 Write row0 slice0 = 000101 (WL[0] DIN=101, WL[1] DIN=000); RN row0 = 000001; I row0 line0 = 1; START MODE=0 -> DOUTP[0]=1, DOUTN[0]=0, ACC[0]=+1, DONE 2 cycles after START.
REQ-039 Row1 slice1 = 100011, RN row1 = 000010, I row1 line1 = 1, MODE=0 -> DOUTN[3]=1, ACC[3]=-1; RN row1 = 100000 -> no hit (sign bit excluded).
REQ-040 MODE=1 LEN=8 with a constant positive hit -> BUSY for 8 cycles, ACC[0]=+8, DONE at cycle 9 after START.
REQ-041 MODE=1 LEN=4, RN alternating hit-positive/hit-negative -> ACC field = 0; LEN=0 -> DONE next cycle, ACC=0, BUSY never high.
REQ-042 During RUN: START and WRITE_EN pulses -> no restart and no weight change; RESET asserted at cycle 3 of LEN=8 -> ACC=0, BUSY=0, no DONE.
